// File: rtl/transpose_pkg.sv
// transpose_pkg
//   Shared definitions for the transpose read path: the read-controller
//   FSM encoding and the default geometry/latency constants that the
//   transpose memory and its read controller must agree on.
//   No ports (package).
package transpose_pkg;

  // Default geometry shared with the transpose memory
  localparam int DEF_MATRIX_DIM = 4;
  localparam int DEF_MEM_WIDTH  = 8;
  localparam int DEF_RD_LATENCY = 5;
  localparam int DEF_FIFO_DEPTH = 4;

  // Read-controller sequence states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/transpose_read_ctrl_sync_fifo.sv
// sync_fifo
//   Single-clock FIFO used as the output buffer of the transpose read
//   controller. A push and a pop in the same cycle both take effect, even
//   when the FIFO is full. Pops of an empty FIFO are ignored.
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   push, push_data  write strobe and data
//   pop              read strobe (head advances)
//   pop_data         current head entry (valid when empty=0)
//   empty            no entries stored
//   count            number of stored entries (0..DEPTH)
module sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  // A full FIFO can still accept a push when the head leaves in the same
  // cycle, because the slot being written is not the one being read.
  assign do_pop  = pop & (count_q != '0);
  assign do_push = push & ((count_q != CW'(DEPTH)) | do_pop);

  // Next-state for storage, pointers and occupancy. DEPTH is a power of
  // two so the pointers wrap naturally.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  // State registers; storage is cleared too so no stale row survives reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign empty    = (count_q == '0);
  assign count    = count_q;

endmodule

// File: rtl/transpose_read_ctrl.sv
// transpose_read_ctrl
//   Reads a whole MATRIX_DIM x MATRIX_DIM matrix out of the transpose
//   memory one column at a time and streams the columns out through a
//   valid/ready interface. Reads are only issued while the output buffer
//   has room for every read still in flight, so returning data is never
//   dropped even under sustained backpressure.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   start                 begin a full-matrix read (only honoured when idle)
//   busy                  a sequence is in progress
//   done                  one-cycle pulse when the last column has left
//   mem_ren, mem_raddr    read strobe and column index to the memory
//   mem_rdata             column data, RD_LATENCY cycles after mem_ren
//   out_data, out_valid,
//   out_ready, out_last   output stream; out_last marks the final column
module transpose_read_ctrl
  import transpose_pkg::*;
#(
  parameter int MATRIX_DIM = DEF_MATRIX_DIM,
  parameter int MEM_WIDTH  = DEF_MEM_WIDTH,
  parameter int ROW_WIDTH  = MATRIX_DIM * MEM_WIDTH,
  parameter int ADDR_LEN   = $clog2(MATRIX_DIM),
  parameter int RD_LATENCY = DEF_RD_LATENCY,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 mem_ren,
  output logic [ADDR_LEN-1:0]  mem_raddr,
  input  logic [ROW_WIDTH-1:0] mem_rdata,
  output logic [ROW_WIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last
);

  // Occupancy/inflight counts hold 0..FIFO_DEPTH; credit gets one extra
  // bit so the subtraction can never wrap.
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int CRW = CW + 1;

  state_e                state_q, state_d;
  logic [ADDR_LEN-1:0]   col_q, col_d;
  logic [CW-1:0]         inflight_q, inflight_d;
  logic [RD_LATENCY-1:0] pipe_valid_q, pipe_valid_d;
  logic [RD_LATENCY-1:0] pipe_last_q, pipe_last_d;

  logic [CW-1:0]         fifo_count;
  logic                  fifo_empty;
  logic [ROW_WIDTH:0]    fifo_rdata;
  logic [CRW-1:0]        credit;
  logic                  issue;
  logic                  push;
  logic                  pop;
  logic                  last_col;

  assign credit   = CRW'(FIFO_DEPTH) - CRW'(fifo_count) - CRW'(inflight_q);
  assign last_col = (col_q == ADDR_LEN'(MATRIX_DIM - 1));
  assign push     = pipe_valid_q[RD_LATENCY-1];
  assign pop      = ~fifo_empty & out_ready;

  // Sequencer: issue one read per cycle while credit allows, then wait for
  // every issued column to leave the buffer before signalling done.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    issue   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ISSUE;
          col_d   = '0;
        end
      end
      ISSUE: begin
        busy = 1'b1;
        if (credit != '0) begin
          issue = 1'b1;
          col_d = col_q + ADDR_LEN'(1);
          if (last_col) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if ((inflight_q == '0) && fifo_empty && !push) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign mem_ren   = issue;
  assign mem_raddr = issue ? col_q : '0;

  // Latency tracker: each issued read walks down the shift pipe and is
  // pushed into the buffer when it reaches the end, exactly as its data
  // appears on mem_rdata. The last flag rides along with it.
  always_comb begin
    pipe_valid_d = RD_LATENCY'({pipe_valid_q, issue});
    pipe_last_d  = RD_LATENCY'({pipe_last_q, issue & last_col});
    inflight_d   = inflight_q + CW'(issue) - CW'(push);
  end

  // State registers. Clearing the pipe on reset is what makes late
  // mem_rdata from an aborted sequence harmless.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      col_q        <= '0;
      inflight_q   <= '0;
      pipe_valid_q <= '0;
      pipe_last_q  <= '0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      inflight_q   <= inflight_d;
      pipe_valid_q <= pipe_valid_d;
      pipe_last_q  <= pipe_last_d;
    end
  end

  sync_fifo #(
    .WIDTH (ROW_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_out_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({pipe_last_q[RD_LATENCY-1], mem_rdata}),
    .pop       (pop),
    .pop_data  (fifo_rdata),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Outputs are gated with valid so an empty buffer always shows zeros.
  assign out_valid = ~fifo_empty;
  assign out_data  = out_valid ? fifo_rdata[ROW_WIDTH-1:0] : '0;
  assign out_last  = out_valid & fifo_rdata[ROW_WIDTH];

endmodule

// File: tb/tb_transpose_read_ctrl.sv
// tb_transpose_read_ctrl
//   Scoreboard bench for transpose_read_ctrl. Each accepted start pushes
//   the four expected read addresses and output beats; a monitor on the
//   falling edge pops and compares whatever the DUT presents. A small
//   latency-line memory model answers every read RD_LATENCY cycles later.
module tb_transpose_read_ctrl;

  localparam int MATRIX_DIM = 4;
  localparam int MEM_WIDTH  = 8;
  localparam int ROW_WIDTH  = 32;
  localparam int ADDR_LEN   = 2;
  localparam int RD_LATENCY = 5;
  localparam int FIFO_DEPTH = 4;
  localparam logic [31:0] MEM_BASE = 32'hC0C1C2C3;

  logic                 clk;
  logic                 rst_n;
  logic                 start;
  logic                 busy;
  logic                 done;
  logic                 mem_ren;
  logic [ADDR_LEN-1:0]  mem_raddr;
  logic [ROW_WIDTH-1:0] mem_rdata;
  logic [ROW_WIDTH-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_last;

  transpose_read_ctrl #(
    .MATRIX_DIM (MATRIX_DIM),
    .MEM_WIDTH  (MEM_WIDTH),
    .ROW_WIDTH  (ROW_WIDTH),
    .ADDR_LEN   (ADDR_LEN),
    .RD_LATENCY (RD_LATENCY),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .mem_ren   (mem_ren),
    .mem_raddr (mem_raddr),
    .mem_rdata (mem_rdata),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } beat_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ready_mode = 1;
  int base_cyc = 0;

  beat_t          exp_beats[$];
  logic [1:0]     exp_addr[$];
  int issued = 0;
  int popped = 0;
  int done_count = 0;
  int valid_seen = 0;
  int reads_seq = 0;
  int first_ren_cyc = -1;
  int last_ren_cyc = -1;
  int first_valid_cyc = -1;
  int last_flag_cyc = -1;
  int done_cyc = -1;
  logic        stall_q = 1'b0;
  logic [31:0] stall_data = '0;
  logic        stall_last = 1'b0;

  // Every comparison goes through here so counts and FAIL lines stay uniform.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Cycle counter: the cycle after edge N is numbered N.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Memory model: a read seen in cycle t is answered in cycle t+RD_LATENCY
  // with MEM_BASE+column; every other cycle carries random garbage.
  logic       samp_ren;
  logic [1:0] samp_addr;
  logic       lat_v [RD_LATENCY];
  logic [1:0] lat_a [RD_LATENCY];

  initial begin
    samp_ren  = 1'b0;
    samp_addr = '0;
    forever begin
      @(negedge clk);
      samp_ren  = mem_ren;
      samp_addr = mem_raddr;
    end
  end

  initial begin
    for (int i = 0; i < RD_LATENCY; i++) begin
      lat_v[i] = 1'b0;
      lat_a[i] = '0;
    end
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = RD_LATENCY - 1; i > 0; i--) begin
        lat_v[i] = lat_v[i-1];
        lat_a[i] = lat_a[i-1];
      end
      lat_v[0] = samp_ren;
      lat_a[0] = samp_addr;
      mem_rdata = lat_v[RD_LATENCY-1] ? (MEM_BASE + 32'(lat_a[RD_LATENCY-1]))
                                      : $urandom;
    end
  end

  // Ready driver: 0 = held low, 1 = held high, 2 = toggling, 3 = random.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        2:       out_ready = ~out_ready;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: samples mid-cycle, checks reads, beats, hold-under-stall,
  // the outstanding-credit bound and the state at each done pulse.
  initial begin
    beat_t b;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (mem_ren) begin
          checkOutput("read_expected", 64'(exp_addr.size() > 0), 64'd1);
          if (exp_addr.size() > 0) begin
            checkOutput("read_addr", 64'(mem_raddr), 64'(exp_addr.pop_front()));
          end
          checkOutput("credit_bound", 64'((issued - popped) < FIFO_DEPTH), 64'd1);
          issued++;
          reads_seq++;
          if (first_ren_cyc < 0) first_ren_cyc = cyc;
          last_ren_cyc = cyc;
        end else begin
          checkOutput("raddr_idle_zero", 64'(mem_raddr), 64'd0);
        end

        if (stall_q) begin
          checkOutput("hold_valid", 64'(out_valid), 64'd1);
          checkOutput("hold_data", 64'(out_data), 64'(stall_data));
          checkOutput("hold_last", 64'(out_last), 64'(stall_last));
        end

        if (out_valid) begin
          valid_seen++;
          if (first_valid_cyc < 0) first_valid_cyc = cyc;
          if (out_last) last_flag_cyc = cyc;
        end

        if (out_valid && out_ready) begin
          checkOutput("beat_expected", 64'(exp_beats.size() > 0), 64'd1);
          if (exp_beats.size() > 0) begin
            b = exp_beats.pop_front();
            checkOutput("beat_data", 64'(out_data), 64'(b.data));
            checkOutput("beat_last", 64'(out_last), 64'(b.last));
          end
          popped++;
        end

        stall_q    = out_valid && !out_ready;
        stall_data = out_data;
        stall_last = out_last;

        if (done) begin
          done_count++;
          done_cyc = cyc;
          checkOutput("done_beats_drained", 64'(exp_beats.size()), 64'd0);
          checkOutput("done_reads_drained", 64'(exp_addr.size()), 64'd0);
          checkOutput("done_outstanding", 64'(issued - popped), 64'd0);
        end
      end
    end
  end

  // Reference model: one accepted start means columns 0..MATRIX_DIM-1 are
  // read in order and come out as MEM_BASE+col, last flag on the final one.
  task automatic pushExpected();
    for (int c = 0; c < MATRIX_DIM; c++) begin
      exp_addr.push_back(2'(c));
      exp_beats.push_back('{data: MEM_BASE + 32'(c), last: (c == MATRIX_DIM - 1)});
    end
    reads_seq       = 0;
    valid_seen      = 0;
    first_ren_cyc   = -1;
    last_ren_cyc    = -1;
    first_valid_cyc = -1;
    last_flag_cyc   = -1;
    done_cyc        = -1;
  endtask

  task automatic flushScoreboard();
    exp_beats.delete();
    exp_addr.delete();
    issued     = 0;
    popped     = 0;
    stall_q    = 1'b0;
    valid_seen = 0;
    reads_seq  = 0;
  endtask

  // Pulse start for one edge; the caller says whether the DUT should take it.
  task automatic applyStimulus(input bit accept);
    if (accept) pushExpected();
    start    = 1'b1;
    base_cyc = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic waitDone(input int max_cycles, input string name);
    int n = 0;
    while (!done && n < max_cycles) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput({name, "_done_seen"}, 64'(done), 64'd1);
  endtask

  task automatic checkQuiet(input string tag);
    checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
    checkOutput({tag, "_done"}, 64'(done), 64'd0);
    checkOutput({tag, "_mem_ren"}, 64'(mem_ren), 64'd0);
    checkOutput({tag, "_mem_raddr"}, 64'(mem_raddr), 64'd0);
    checkOutput({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    checkOutput({tag, "_out_last"}, 64'(out_last), 64'd0);
    checkOutput({tag, "_out_data"}, 64'(out_data), 64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int dc0;
    int n;
    rst_n = 1'b0;
    start = 1'b0;
    ready_mode = 1;
    repeat (3) @(posedge clk);
    #1;
    checkQuiet("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Free flow with exact cycle timing
    $display("[TB] free flow");
    dc0 = done_count;
    applyStimulus(1'b1);
    waitDone(40, "free");
    @(negedge clk);
    #1;
    checkOutput("free_first_ren", 64'(first_ren_cyc), 64'(base_cyc + 1));
    checkOutput("free_last_ren", 64'(last_ren_cyc), 64'(base_cyc + 4));
    checkOutput("free_reads", 64'(reads_seq), 64'd4);
    checkOutput("free_first_valid", 64'(first_valid_cyc), 64'(base_cyc + 7));
    checkOutput("free_valid_beats", 64'(valid_seen), 64'd4);
    checkOutput("free_last_cycle", 64'(last_flag_cyc), 64'(base_cyc + 10));
    checkOutput("free_done_cycle", 64'(done_cyc), 64'(base_cyc + 11));
    checkOutput("free_done_count", 64'(done_count - dc0), 64'd1);
    @(posedge clk);
    #1;
    checkOutput("free_idle_busy", 64'(busy), 64'd0);

    // Full backpressure: buffer fills, reads stop, then drains in order
    $display("[TB] backpressure");
    ready_mode = 0;
    @(posedge clk);
    #1;
    applyStimulus(1'b1);
    repeat (20) begin
      @(posedge clk);
      #1;
    end
    checkOutput("bp_reads", 64'(reads_seq), 64'd4);
    checkOutput("bp_ren_low", 64'(mem_ren), 64'd0);
    checkOutput("bp_valid", 64'(out_valid), 64'd1);
    checkOutput("bp_busy", 64'(busy), 64'd1);
    checkOutput("bp_buffered", 64'(issued - popped), 64'd4);
    ready_mode = 1;
    waitDone(40, "bp");

    // Toggling ready exercises the credit limit
    $display("[TB] credit limit");
    ready_mode = 2;
    @(posedge clk);
    #1;
    applyStimulus(1'b1);
    waitDone(60, "credit");
    checkOutput("credit_reads", 64'(reads_seq), 64'd4);

    // Extra starts during ISSUE and DRAIN must be ignored
    $display("[TB] ignored start");
    ready_mode = 1;
    @(posedge clk);
    #1;
    dc0 = done_count;
    applyStimulus(1'b1);
    applyStimulus(1'b0);
    n = 0;
    while (reads_seq < 4 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("ign_busy_in_drain", 64'(busy), 64'd1);
    applyStimulus(1'b0);
    waitDone(40, "ign");
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    checkOutput("ign_done_count", 64'(done_count - dc0), 64'd1);
    checkOutput("ign_reads", 64'(reads_seq), 64'd4);

    // Reset after two reads: everything clears, late data is ignored
    $display("[TB] reset mid-op");
    applyStimulus(1'b1);
    n = 0;
    while (reads_seq < 2 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput("rst_two_reads", 64'(reads_seq), 64'd2);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkQuiet("midrst");
    flushScoreboard();
    rst_n = 1'b1;
    repeat (12) begin
      @(posedge clk);
      #1;
    end
    checkOutput("rst_no_late_valid", 64'(valid_seen), 64'd0);
    applyStimulus(1'b1);
    waitDone(40, "rst_restart");
    checkOutput("rst_restart_reads", 64'(reads_seq), 64'd4);

    // Back-to-back: start raised in the done cycle and held into IDLE
    $display("[TB] back-to-back");
    @(posedge clk);
    #1;
    dc0 = done_count;
    applyStimulus(1'b1);
    waitDone(40, "b2b_first");
    start = 1'b1;
    @(negedge clk);
    #1;
    pushExpected();
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    start = 1'b0;
    waitDone(40, "b2b_second");
    @(negedge clk);
    #1;
    checkOutput("b2b_done_count", 64'(done_count - dc0), 64'd2);
    checkOutput("b2b_reads", 64'(reads_seq), 64'd4);

    // Random ready with random gaps between sequences
    $display("[TB] random ready");
    ready_mode = 3;
    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(1, 6)) begin
        @(posedge clk);
        #1;
      end
      applyStimulus(1'b1);
      waitDone(200, "rand");
      checkOutput("rand_reads", 64'(reads_seq), 64'd4);
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
